count_spi_reader: RTL and testbench

COUNT_SPI_READER -- requirements
Module: count_spi_reader

---
 rtl/count_spi_reader.sv | 210 +++++++++++++++++++++
 tb/tb_count_spi_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_spi_reader.sv
// count_spi_reader: SPI mode-0 slave that returns one count word popped from
// an external FIFO (READ_COUNT, 8'h01) or a status byte (READ_STATUS, 8'h02).
// SPI pins are asynchronous to clk_12mhz and are sampled through 3-flop
// synchronizers; all SPI edge handling runs on the synchronized copies.
//
// FIFO handshake: fifo_rd_en is a one-cycle pop strobe raised only while
// fifo_empty=0; the popped word is valid on fifo_data in the following cycle
// and is captured at the end of that cycle (state LOAD).
module count_spi_reader #(
  parameter int CNT_W       = 24,
  parameter int SCK_MIN_DIV = 8
) (
  input  logic             clk_12mhz,
  input  logic             reset,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  input  logic [CNT_W-1:0] fifo_data,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic [3:0]       fifo_level,
  output logic             fifo_rd_en,
  output logic             busy,
  output logic             underrun
);

  // Load completes 3 cycles after the 8th SCK rise is seen, and each SCK
  // half period needs at least 3 samples for reliable edge detection.
  generate
    if (SCK_MIN_DIV < 6 || CNT_W < 8) begin : g_bad_param
      $error("count_spi_reader: SCK_MIN_DIV must be >= 6 and CNT_W >= 8");
    end
  endgenerate

  localparam int BW = $clog2(CNT_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam logic [7:0] CMD_READ_COUNT  = 8'h01;
  localparam logic [7:0] CMD_READ_STATUS = 8'h02;

  localparam logic [BW-1:0] LAST_CMD_BIT  = BW'(7);
  localparam logic [BW-1:0] LAST_STAT_BIT = BW'(7);
  localparam logic [BW-1:0] LAST_CNT_BIT  = BW'(CNT_W - 1);

  logic [2:0]       r_sck_sync;
  logic [2:0]       r_cs_sync;
  logic [2:0]       r_mosi_sync;
  logic [1:0]       r_fill;
  logic             r_armed;
  logic [2:0]       r_state;
  logic [7:0]       r_cmd;
  logic [BW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0] r_shift;
  logic             r_underrun;
  logic             r_is_status;
  logic             r_use_fifo;
  logic             r_skip_fall;

  logic             w_cs_low;
  logic             w_cs_fall;
  logic             w_cs_rise;
  logic             w_sck_rise;
  logic             w_sck_fall;
  logic [7:0]       w_cmd_next;
  logic [7:0]       w_status;
  logic [BW-1:0]    w_last_data_bit;

  assign w_cs_low        = ~r_cs_sync[1];
  assign w_cs_fall       = (r_cs_sync[2:1] == 2'b10);
  assign w_cs_rise       = (r_cs_sync[2:1] == 2'b01);
  // SCK edges only count while chip select is low.
  assign w_sck_rise      = (r_sck_sync[2:1] == 2'b01) & w_cs_low;
  assign w_sck_fall      = (r_sck_sync[2:1] == 2'b10) & w_cs_low;
  // MOSI stage 2 was sampled together with the SCK-low sample before the rise.
  assign w_cmd_next      = {r_cmd[6:0], r_mosi_sync[2]};
  assign w_status        = {r_underrun, fifo_full, fifo_empty, 1'b0, fifo_level};
  assign w_last_data_bit = r_is_status ? LAST_STAT_BIT : LAST_CNT_BIT;

  assign spi_miso   = (r_state == S_SHIFT) ? r_shift[CNT_W-1] : 1'b0;
  assign busy       = (r_state != S_IDLE);
  assign underrun   = r_underrun;
  // Gated by reset so a reset landing on FETCH never pops.
  assign fifo_rd_en = reset & (r_state == S_FETCH) & ~fifo_empty;

  // Three-stage synchronizers for the asynchronous SPI pins.
  always_ff @(posedge clk_12mhz) begin
    if (!reset) begin
      r_sck_sync  <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 3'b000;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[1:0], spi_mosi};
    end
  end

  // Arm frame start only after a genuine high CS level has been synchronized,
  // so a CS held low across reset release cannot look like a falling edge.
  always_ff @(posedge clk_12mhz) begin
    if (!reset) begin
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1] && r_cs_sync[1]) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Frame FSM: command capture, FIFO fetch, load and MSB-first shift-out.
  always_ff @(posedge clk_12mhz) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cmd       <= 8'h00;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_underrun  <= 1'b0;
      r_is_status <= 1'b0;
      r_use_fifo  <= 1'b0;
      r_skip_fall <= 1'b0;
    end else begin
      // The fall that ends the 8th command bit must not shift out data.
      if (w_sck_fall) begin
        r_skip_fall <= 1'b0;
      end
      if (w_cs_rise) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall && r_armed) begin
              r_state     <= S_CMD;
              r_cmd       <= 8'h00;
              r_bit_cnt   <= '0;
              r_skip_fall <= 1'b0;
            end
          end
          S_CMD: begin
            if (w_sck_rise) begin
              r_cmd <= w_cmd_next;
              if (r_bit_cnt == LAST_CMD_BIT) begin
                r_bit_cnt   <= '0;
                r_skip_fall <= 1'b1;
                case (w_cmd_next)
                  CMD_READ_COUNT: begin
                    r_is_status <= 1'b0;
                    r_state     <= S_FETCH;
                  end
                  CMD_READ_STATUS: begin
                    r_is_status <= 1'b1;
                    r_state     <= S_LOAD;
                  end
                  default: r_state <= S_DRAIN;
                endcase
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (!fifo_empty) begin
              r_use_fifo <= 1'b1;
            end else begin
              r_use_fifo <= 1'b0;
              r_underrun <= 1'b1;
            end
            r_state <= S_LOAD;
          end
          S_LOAD: begin
            if (r_is_status) begin
              r_shift    <= CNT_W'(w_status) << (CNT_W - 8);
              r_underrun <= 1'b0;
            end else if (r_use_fifo) begin
              r_shift <= fifo_data;
            end else begin
              r_shift <= '1;
            end
            r_state <= S_SHIFT;
          end
          S_SHIFT: begin
            if (w_sck_fall && !r_skip_fall) begin
              r_shift <= {r_shift[CNT_W-2:0], 1'b0};
              if (r_bit_cnt == w_last_data_bit) begin
                r_bit_cnt <= '0;
                r_state   <= S_DRAIN;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            r_state <= S_DRAIN;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_spi_reader.sv
// Directed testbench for count_spi_reader: SPI host driven at clk/8 with a
// small FIFO model on the count side.
module tb_count_spi_reader;

  logic        clk_12mhz = 1'b0;
  logic        reset;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [23:0] fifo_data = 24'h0;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  fifo_level;
  logic        fifo_rd_en;
  logic        busy;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] fifo_mem [0:15];
  int          wr_ptr    = 0;
  int          rd_ptr    = 0;
  int          pop_count = 0;
  int          bad_pops  = 0;

  // clock / reset block
  always #5 clk_12mhz = ~clk_12mhz;

  count_spi_reader #(.CNT_W(24), .SCK_MIN_DIV(8)) dut (
    .clk_12mhz (clk_12mhz),
    .reset     (reset),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_level(fifo_level),
    .fifo_rd_en(fifo_rd_en),
    .busy      (busy),
    .underrun  (underrun)
  );

  // FIFO model: data valid the cycle after the pop strobe.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk_12mhz) begin
    if (fifo_rd_en) begin
      if (fifo_empty) bad_pops <= bad_pops + 1;
      fifo_data <= fifo_mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_12mhz);
  endtask

  task automatic fifo_push(input logic [23:0] w);
    fifo_mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clks(4);
    spi_sck = 1'b1;
    m = spi_miso;
    wait_clks(4);
    spi_sck = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int ndata,
                           output logic [7:0] cmd_miso, output logic [31:0] data,
                           output logic busy_seen);
    logic m;
    spi_cs_n = 1'b0;
    wait_clks(4);
    cmd_miso = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(cmd[i], m);
      cmd_miso = {cmd_miso[6:0], m};
    end
    busy_seen = busy;
    data = 32'h0;
    for (int i = 0; i < ndata; i++) begin
      spi_bit(1'b0, m);
      data = {data[30:0], m};
    end
  endtask

  task automatic cs_release();
    wait_clks(4);
    spi_cs_n = 1'b1;
    wait_clks(8);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    fifo_full = 1'b0; fifo_level = 4'h0;
    repeat (3) @(posedge clk_12mhz);
    #1;
    n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    @(negedge clk_12mhz);
    reset = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_read_count();
    logic [7:0] cm; logic [31:0] d; logic bs; int p0;
    fifo_push(24'hA5C3F0);
    p0 = pop_count;
    spi_frame(8'h01, 24, cm, d, bs);
    n_checks++; if (cm !== 8'h00) begin n_fail++; $display("FAIL rc_cmd_miso: got %h expected 00", cm); end
    n_checks++; if (bs !== 1'b1) begin n_fail++; $display("FAIL rc_busy: got %b expected 1", bs); end
    n_checks++; if (d[23:0] !== 24'hA5C3F0) begin n_fail++; $display("FAIL rc_data: got %h expected a5c3f0", d[23:0]); end
    n_checks++; if (pop_count - p0 !== 1) begin n_fail++; $display("FAIL rc_pops: got %0d expected 1", pop_count - p0); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rc_underrun: got %b expected 0", underrun); end
    cs_release();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rc_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_underrun();
    logic [7:0] cm; logic [31:0] d; logic bs; int p0;
    p0 = pop_count;
    spi_frame(8'h01, 24, cm, d, bs);
    n_checks++; if (d[23:0] !== 24'hFFFFFF) begin n_fail++; $display("FAIL ur_data: got %h expected ffffff", d[23:0]); end
    n_checks++; if (pop_count - p0 !== 0) begin n_fail++; $display("FAIL ur_pops: got %0d expected 0", pop_count - p0); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_flag: got %b expected 1", underrun); end
    cs_release();
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_sticky: got %b expected 1", underrun); end
    spi_frame(8'h02, 8, cm, d, bs);
    n_checks++; if (d[7:0] !== 8'hA0) begin n_fail++; $display("FAIL ur_status: got %h expected a0", d[7:0]); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear: got %b expected 0", underrun); end
    cs_release();
  endtask

  task automatic test_bad_cmd();
    logic [7:0] cm; logic [31:0] d; logic bs; int p0;
    fifo_push(24'h5A5A5A);
    p0 = pop_count;
    spi_frame(8'h7E, 24, cm, d, bs);
    n_checks++; if (d[23:0] !== 24'h000000) begin n_fail++; $display("FAIL bad_data: got %h expected 000000", d[23:0]); end
    n_checks++; if (pop_count - p0 !== 0) begin n_fail++; $display("FAIL bad_pops: got %0d expected 0", pop_count - p0); end
    wait_clks(4);
    spi_cs_n = 1'b1;
    @(posedge clk_12mhz); @(posedge clk_12mhz); #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bad_busy_hold: got %b expected 1", busy); end
    @(posedge clk_12mhz); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_busy_fall: got %b expected 0", busy); end
    wait_clks(8);
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pop_count;
    @(negedge clk_12mhz); spi_cs_n = 1'b0;
    @(negedge clk_12mhz); spi_cs_n = 1'b1;
    wait_clks(6);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    n_checks++; if (pop_count - p0 !== 0) begin n_fail++; $display("FAIL glitch_pops: got %0d expected 0", pop_count - p0); end
  endtask

  task automatic test_status_full();
    logic [7:0] cm; logic [31:0] d; logic bs; int p0;
    fifo_full = 1'b1; fifo_level = 4'hF;
    p0 = pop_count;
    spi_frame(8'h02, 8, cm, d, bs);
    n_checks++; if (d[7:0] !== 8'h4F) begin n_fail++; $display("FAIL st_status: got %h expected 4f", d[7:0]); end
    n_checks++; if (pop_count - p0 !== 0) begin n_fail++; $display("FAIL st_pops: got %0d expected 0", pop_count - p0); end
    cs_release();
    fifo_full = 1'b0; fifo_level = 4'h0;
  endtask

  task automatic test_abort();
    logic [7:0] cm; logic [31:0] d; logic bs; int p0;
    fifo_push(24'h123456);
    p0 = pop_count;
    spi_frame(8'h01, 10, cm, d, bs);
    cs_release();
    n_checks++; if (d[9:0] !== 10'h169) begin n_fail++; $display("FAIL ab_bits: got %h expected 169", d[9:0]); end
    n_checks++; if (pop_count - p0 !== 1) begin n_fail++; $display("FAIL ab_pops: got %0d expected 1", pop_count - p0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_idle: got %b expected 0", busy); end
    p0 = pop_count;
    spi_frame(8'h01, 24, cm, d, bs);
    n_checks++; if (d[23:0] !== 24'h123456) begin n_fail++; $display("FAIL ab_next: got %h expected 123456", d[23:0]); end
    n_checks++; if (pop_count - p0 !== 1) begin n_fail++; $display("FAIL ab_next_pops: got %0d expected 1", pop_count - p0); end
    cs_release();
  endtask

  task automatic test_reset_mid();
    logic [7:0] cm; logic [31:0] d; logic bs; logic m; int p0;
    fifo_push(24'h1E2D3C);
    fifo_push(24'h0F1E2D);
    spi_frame(8'h01, 3, cm, d, bs);
    wait_clks(4);
    n_checks++; if (spi_miso !== 1'b1) begin n_fail++; $display("FAIL rm_pre_miso: got %b expected 1", spi_miso); end
    reset = 1'b0;
    @(posedge clk_12mhz); #1;
    n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL rm_miso: got %b expected 0", spi_miso); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rm_rd_en: got %b expected 0", fifo_rd_en); end
    wait_clks(2);
    reset = 1'b1;
    p0 = pop_count;
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    wait_clks(4);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_cs_low_start: got %b expected 0", busy); end
    spi_cs_n = 1'b1;
    wait_clks(8);
    spi_frame(8'h01, 24, cm, d, bs);
    n_checks++; if (d[23:0] !== 24'h0F1E2D) begin n_fail++; $display("FAIL rm_next: got %h expected 0f1e2d", d[23:0]); end
    n_checks++; if (pop_count - p0 !== 1) begin n_fail++; $display("FAIL rm_pops: got %0d expected 1", pop_count - p0); end
    cs_release();
  endtask

  // scoreboard sequence and final report
  initial begin
    test_reset();
    test_read_count();
    test_underrun();
    test_bad_cmd();
    test_glitch();
    test_status_full();
    test_abort();
    test_reset_mid();
    n_checks++; if (bad_pops !== 0) begin n_fail++; $display("FAIL pop_while_empty: got %0d expected 0", bad_pops); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
